unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Arbitrates the single shared instruction/data memory between the fetch
//  stage (IF) and the MEM-stage load/store port, replacing clock-phase muxing.
//  Latches the winning request, holds the memory port for MEM_LAT cycles, and
//  returns read data with a one-cycle valid pulse. Pipeline stalls derive from
//  the if_valid/d_valid handshake.
// PARAMETERS
//  ADDR_W      8  memory byte-address width
//  MEM_LAT     2  cycles the memory port is held per access (>=1)
//  STARVE_MAX  4  consecutive data wins over a waiting fetch before fetch is forced
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  if_req     in   1       fetch request (level)
//  if_addr    in   ADDR_W  fetch byte address
//  if_flush   in   1       cancel outstanding fetch (branch/jump taken)
//  if_gnt     out  1       fetch accepted this cycle
//  if_valid   out  1       fetch data valid (1-cycle pulse)
//  if_rdata   out  32      fetched instruction
//  d_req      in   1       data request (level)
//  d_we       in   1       1=store, 0=load
//  d_func3    in   3       access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   32      store data
//  d_gnt      out  1       data access accepted this cycle
//  d_valid    out  1       load data valid / store done (1-cycle pulse)
//  d_rdata    out  32      load data
//  m_addr     out  ADDR_W  memory address
//  m_read     out  1       memory read enable
//  m_write    out  1       memory write enable
//  m_func3    out  3       memory access size (fetch forces 3'b010)
//  m_wdata    out  32      memory write data
//  m_rdata    in   32      memory read data
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE; starve_cnt=0; all outputs 0 the cycle after rst is
//    sampled high. This includes an access in flight: it is abandoned,
//    m_read/m_write drop, and no valid is issued.
//  - FSM states: IDLE -> ACCESS (MEM_LAT cycles, counted by lat_cnt) -> RESP -> IDLE.
//  - IDLE:
//    - Requests are sampled only in IDLE.
//    - The winner gets gnt for 1 cycle (combinational in that IDLE cycle).
//    - addr/we/func3/wdata and the owner are latched; next state is ACCESS.
//  - Priority when both requests are high: data wins, unless starve_cnt==STARVE_MAX,
//    in which case fetch wins.
//    - starve_cnt increments, saturating, when data wins while if_req=1.
//    - starve_cnt clears to 0 when fetch is granted.
//  - ACCESS:
//    - m_* are driven from the latched fields every cycle.
//    - m_read=~we; m_write=we and is held all MEM_LAT cycles (rewriting the same
//      data is idempotent).
//    - On the last ACCESS cycle, m_rdata is captured into the owner's rdata register.
//  - RESP:
//    - m_read=m_write=0.
//    - The owner's valid pulses for 1 cycle; next state is IDLE.
//    - Store: d_valid pulses and d_rdata is unchanged.
//  - Latency: gnt at T; ACCESS T+1..T+MEM_LAT; valid at T+MEM_LAT+1.
//  - Throughput: one access per MEM_LAT+2 cycles.
//  - Requesters drop req in their valid cycle. req high in the following IDLE
//    cycle is a new access.
//  - if_flush:
//    - In any non-IDLE state with owner=IF, sets a cancel flag. The access still
//      completes on the port, but if_valid is suppressed in RESP and if_rdata is
//      not updated. The flag clears in IDLE.
//    - In IDLE, if_flush blocks fetch grant that cycle.
//    - It has no effect on data accesses.
//  - rdata registers hold their value between accesses. gnt and valid are never
//    high for both ports in the same cycle.
// TESTING (MEM_LAT=2, STARVE_MAX=4)
//  - Reset: assert rst for 1 cycle mid-ACCESS of a store -> next cycle
//    m_write=0, busy=0, all valid/gnt=0; no d_valid ever issued.
//  - Fetch: if_req, if_addr=8'h10, m_rdata=32'h00500093 -> if_gnt@T,
//    m_read=1 and m_func3=3'b010 for T+1..T+2, if_valid=1 with if_rdata=32'h00500093 @T+3.
//  - Contention: if_req and d_req (load 8'h20) both high @T -> d_gnt@T,
//    d_valid@T+3, if_gnt@T+4, if_valid@T+7.
//  - Starvation: d_req and if_req held high -> 4 data grants, then the 5th
//    arbitration grants fetch; starve_cnt=0 afterwards.
//  - Flush: fetch granted @T, if_flush=1 @T+1 -> m_read still high T+1..T+2,
//    no if_valid @T+3, busy=0 @T+4.
//  - Store/load: SW 32'hDEADBEEF @8'h20 -> m_write T+1..T+2, d_valid@T+3;
//    a following LW of 8'h20 returns d_rdata=32'hDEADBEEF.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shared instruction/data memory arbiter: grants one of the fetch or load/store ports,
// holds the memory port for MEM_LAT cycles, then returns a one-cycle valid pulse.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [2:0]        m_func3,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                owner_if_q, owner_if_d;
  logic                cancel_q, cancel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [2:0]          func3_q, func3_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  logic starve_full, if_win, d_win, last_access, cancel_now;

  // Arbitration is only live in IDLE; a flush or reset in that cycle vetoes the fetch grant.
  assign starve_full = (starve_q == SW'(STARVE_MAX));
  assign if_win      = (state_q == IDLE) && !rst && if_req && !if_flush && (!d_req || starve_full);
  assign d_win       = (state_q == IDLE) && !rst && d_req && !if_win;
  assign last_access = (state_q == ACCESS) && (lat_q == LAT_W'(MEM_LAT - 1));
  assign cancel_now  = cancel_q || (if_flush && owner_if_q);

  // NOTE: synchronous state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      owner_if_q <= 1'b0;
      cancel_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      func3_q    <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      owner_if_q <= owner_if_d;
      cancel_q   <= cancel_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      func3_q    <= func3_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its flop first, so no path through the case can infer a latch.
    state_d    = state_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    owner_if_d = owner_if_q;
    cancel_d   = cancel_q;
    addr_d     = addr_q;
    we_d       = we_q;
    func3_d    = func3_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        lat_d    = '0;
        if (if_win || d_win) begin
          state_d    = ACCESS;
          owner_if_d = if_win;
          addr_d     = if_win ? if_addr : d_addr;
          we_d       = d_win && d_we;
          func3_d    = if_win ? 3'b010 : d_func3;
          wdata_d    = if_win ? '0 : d_wdata;
        end
        if (if_win)                             starve_d = '0;
        else if (d_win && if_req && !starve_full) starve_d = starve_q + SW'(1);
      end
      ACCESS: begin
        cancel_d = cancel_now;
        if (last_access) begin
          state_d = RESP;
          if (owner_if_q && !cancel_now) if_rdata_d = m_rdata;
          if (!owner_if_q && !we_q)      d_rdata_d  = m_rdata;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RESP: begin
        cancel_d = cancel_now;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt   = if_win;
    d_gnt    = d_win;
    if_valid = 1'b0;
    d_valid  = 1'b0;
    m_addr   = '0;
    m_read   = 1'b0;
    m_write  = 1'b0;
    m_func3  = '0;
    m_wdata  = '0;
    busy     = (state_q != IDLE);
    if (state_q == ACCESS) begin
      m_addr  = addr_q;
      m_read  = !we_q;
      m_write = we_q;
      m_func3 = func3_q;
      m_wdata = wdata_q;
    end
    if (state_q == RESP) begin
      if_valid = owner_if_q && !cancel_now;
      d_valid  = !owner_if_q;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-timeline model with its own mirror of memory contents.
module tb_unified_mem_arbiter;
  localparam int AW = 8;
  localparam int L  = 2;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst, if_req, if_flush, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, m_addr;
  logic [2:0] d_func3, m_func3;
  logic [31:0] d_wdata, m_wdata, m_rdata, if_rdata, d_rdata;
  logic if_gnt, if_valid, d_gnt, d_valid, m_read, m_write, busy;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_func3(m_func3),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  // Word-addressed memory behind the port; preloaded on the first clock edge.
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h00500093;
    if (i == 8) return 32'h11223344;
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  logic preload;
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (m_write) begin
      mem[m_addr[7:2]] <= m_wdata;
    end
  end
  assign m_rdata = mem[m_addr[7:2]];

  // Model: phase 0 = port free, 1..L = access cycles after grant, L+1 = response cycle.
  int phase, starve, checks, errors, cyc;
  bit own_if, mwe, cancel;
  bit [7:0] maddr;
  bit [2:0] mf3;
  bit [31:0] mwd, exp_if_rdata, exp_d_rdata;
  bit [31:0] mirror [64];

  logic s_if_gnt, s_d_gnt, s_if_valid, s_d_valid, s_m_read, s_m_write, s_busy;
  logic [2:0] s_m_func3;
  logic [31:0] s_if_rdata, s_d_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; starve = 0; cancel = 0; own_if = 0;
    exp_if_rdata = '0; exp_d_rdata = '0;
  endtask

  // One cycle: compare all outputs on the falling edge, advance the model, return after the next rise.
  task automatic tick();
    bit e_ig, e_dg, e_iv, e_dv, e_rd, e_wr;
    bit [7:0] e_addr;
    bit [2:0] e_f3;
    bit [31:0] e_wd;
    bit cnow;
    @(negedge clk);
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_rd = 0; e_wr = 0;
    e_addr = '0; e_f3 = '0; e_wd = '0;
    cnow = cancel || (phase > 0 && own_if && if_flush);
    if (phase == 0 && !rst) begin
      e_ig = if_req && !if_flush && (!d_req || starve == SM);
      e_dg = d_req && !e_ig;
    end
    if (phase >= 1 && phase <= L) begin
      e_rd = !mwe; e_wr = mwe; e_addr = maddr; e_f3 = mf3; e_wd = mwd;
    end
    if (phase == L + 1) begin
      e_iv = own_if && !cnow;
      e_dv = !own_if;
    end
    check("if_gnt", if_gnt, e_ig);
    check("d_gnt", d_gnt, e_dg);
    check("if_valid", if_valid, e_iv);
    check("d_valid", d_valid, e_dv);
    check("m_read", m_read, e_rd);
    check("m_write", m_write, e_wr);
    check("m_addr", m_addr, e_addr);
    check("m_func3", m_func3, e_f3);
    check("m_wdata", m_wdata, e_wd);
    check("busy", busy, phase != 0);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_valid = if_valid; s_d_valid = d_valid;
    s_m_read = m_read; s_m_write = m_write; s_busy = busy; s_m_func3 = m_func3;
    s_if_rdata = if_rdata; s_d_rdata = d_rdata;
    if (rst) begin
      model_reset();
    end else if (phase == 0) begin
      cancel = 0;
      if (e_ig || e_dg) begin
        own_if = e_ig;
        maddr  = e_ig ? if_addr : d_addr;
        mwe    = e_dg && d_we;
        mf3    = e_ig ? 3'b010 : d_func3;
        mwd    = e_ig ? 32'h0 : d_wdata;
        phase  = 1;
        if (mwe) mirror[maddr[7:2]] = mwd;
        if (e_ig) starve = 0;
        else if (if_req && starve < SM) starve++;
      end
    end else begin
      cancel = cnow;
      if (phase == L) begin
        if (own_if && !cnow) exp_if_rdata = mirror[maddr[7:2]];
        if (!own_if && !mwe) exp_d_rdata = mirror[maddr[7:2]];
      end
      phase = (phase == L + 1) ? 0 : phase + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1; if_req = 0; d_req = 0; if_flush = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit i_act, d_act;
    int ng, dv;
    logic [1:0] order [6];
    checks = 0; errors = 0; cyc = 0;
    for (int i = 0; i < 64; i++) mirror[i] = init_word(i);
    model_reset();
    preload = 1; rst = 1;
    if_req = 0; if_addr = '0; if_flush = 0;
    d_req = 0; d_we = 0; d_func3 = '0; d_addr = '0; d_wdata = '0;
    tick();
    preload = 0;
    tick();
    rst = 0;
    tick();
    check("reset_busy", s_busy, 1'b0);
    check("reset_if_rdata", s_if_rdata, 32'h0);

    // Fetch of 0x10
    if_req = 1; if_addr = 8'h10;
    tick(); check("fetch_gnt", s_if_gnt, 1'b1);
    tick(); check("fetch_read1", s_m_read, 1'b1); check("fetch_f3_1", s_m_func3, 3'b010);
    tick(); check("fetch_read2", s_m_read, 1'b1); check("fetch_f3_2", s_m_func3, 3'b010);
    if_req = 0;
    tick(); check("fetch_valid", s_if_valid, 1'b1); check("fetch_rdata", s_if_rdata, 32'h00500093);
    tick();

    // Contention: load 0x20 against fetch 0x14
    if_req = 1; if_addr = 8'h14; d_req = 1; d_we = 0; d_func3 = 3'b010; d_addr = 8'h20;
    tick(); check("cont_dgnt", s_d_gnt, 1'b1); check("cont_no_igant", s_if_gnt, 1'b0);
    run(2);
    d_req = 0;
    tick(); check("cont_dvalid", s_d_valid, 1'b1); check("cont_drdata", s_d_rdata, 32'h11223344);
    tick(); check("cont_igant", s_if_gnt, 1'b1);
    run(2);
    if_req = 0;
    tick(); check("cont_ivalid", s_if_valid, 1'b1);
    tick();

    // Starvation: both held high, grant order must be D D D D F D
    do_reset();
    if_req = 1; if_addr = 8'h18; d_req = 1; d_we = 0; d_func3 = 3'b010; d_addr = 8'h24;
    ng = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      tick();
      if (s_d_gnt) begin order[ng] = 2'd1; ng++; end
      else if (s_if_gnt) begin order[ng] = 2'd2; ng++; end
    end
    check("starve_grants", ng, 6);
    for (int k = 0; k < 6; k++) check($sformatf("starve_order%0d", k), order[k], (k == 4) ? 2'd2 : 2'd1);
    if_req = 0; d_req = 0;
    run(5);

    // Flush during fetch
    if_req = 1; if_addr = 8'h14;
    tick(); check("flush_gnt", s_if_gnt, 1'b1);
    if_req = 0; if_flush = 1;
    tick(); check("flush_read1", s_m_read, 1'b1);
    if_flush = 0;
    tick(); check("flush_read2", s_m_read, 1'b1);
    tick(); check("flush_no_valid", s_if_valid, 1'b0);
    tick(); check("flush_idle", s_busy, 1'b0);

    // Store then load back
    d_req = 1; d_we = 1; d_func3 = 3'b010; d_addr = 8'h20; d_wdata = 32'hDEADBEEF;
    tick(); check("sw_gnt", s_d_gnt, 1'b1);
    tick(); check("sw_write1", s_m_write, 1'b1);
    tick(); check("sw_write2", s_m_write, 1'b1);
    d_req = 0;
    tick(); check("sw_valid", s_d_valid, 1'b1);
    d_req = 1; d_we = 0;
    tick(); check("lw_gnt", s_d_gnt, 1'b1);
    run(2);
    d_req = 0;
    tick(); check("lw_valid", s_d_valid, 1'b1); check("lw_rdata", s_d_rdata, 32'hDEADBEEF);
    tick();

    // Reset in the middle of a store
    d_req = 1; d_we = 1; d_addr = 8'h28; d_wdata = 32'h12345678;
    tick(); check("rst_sw_gnt", s_d_gnt, 1'b1);
    d_req = 0; rst = 1;
    tick();
    rst = 0;
    tick();
    check("rst_mwrite", s_m_write, 1'b0); check("rst_busy", s_busy, 1'b0);
    check("rst_dvalid", s_d_valid, 1'b0); check("rst_ivalid", s_if_valid, 1'b0);
    check("rst_dgnt", s_d_gnt, 1'b0); check("rst_igant", s_if_gnt, 1'b0);
    dv = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (s_d_valid) dv++; end
    check("rst_no_dvalid", dv, 0);

    // Random traffic
    i_act = 0; d_act = 0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if_flush = ($urandom_range(0, 11) == 0);
      if (rst) begin
        i_act = 0; d_act = 0;
      end else begin
        if (phase == L + 1 && own_if) i_act = 0;
        if (phase == L + 1 && !own_if) d_act = 0;
        if (if_flush) if_addr = 8'($urandom);
        if (!i_act && $urandom_range(0, 1) == 1) begin
          i_act = 1; if_addr = 8'($urandom);
        end
        if (!d_act && $urandom_range(0, 2) == 0) begin
          d_act = 1;
          d_we = 1'($urandom);
          d_addr = 8'($urandom);
          d_wdata = $urandom;
          d_func3 = d_we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
          if (d_func3 == 3'b011) d_func3 = 3'b100;
        end
      end
      if_req = i_act; d_req = d_act;
      tick();
    end
    rst = 0; if_req = 0; d_req = 0; if_flush = 0;
    run(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
